// File: rtl/uart_tx_buffered_pkg.sv
// Shared types for the buffered 9N1 UART transmitter.
package uart_pkg;

   localparam int FRAME_BITS = 9;

   typedef logic [FRAME_BITS-1:0] uart_word_t;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Push-side handshake between upstream logic and the buffered UART transmitter.
interface uart_tx_buffered_if;
   import uart_pkg::*;

   logic       send;
   uart_word_t data_tx;
   logic       ready;
   logic       overflow;

   modport master (output send, output data_tx, input ready, input overflow);
   modport slave  (input send, input data_tx, output ready, output overflow);

endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Small synchronous FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the registered count, so a same-cycle pop cannot make room.
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// 9N1 UART transmitter with internal baud timing and a transmit FIFO;
// queued words are sent back-to-back without idle gaps.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604,
   parameter int DEPTH        = 4
) (
   input  logic               clock,
   input  logic               reset,
   uart_tx_buffered_if.slave  bus,
   output logic               tx,
   output logic               busy
);

   localparam int                BW        = $clog2(CLKS_PER_BIT);
   localparam int                CNTW      = $clog2(DEPTH) + 1;
   localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t         state;
   tx_state_t         state_next;
   logic [BW-1:0]     baud_cnt;
   logic [3:0]        bit_idx;
   uart_word_t        shift_reg;
   uart_word_t        fifo_dout;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNTW-1:0]   fifo_count;
   logic              baud_done;
   logic              tx_next;

   sync_fifo #(
      .WIDTH (FRAME_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (bus.send),
      .pop   (fifo_pop),
      .din   (bus.data_tx),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.ready    = (fifo_count != CNTW'(DEPTH));
   assign bus.overflow = bus.send && fifo_full;
   assign baud_done    = (baud_cnt == BAUD_LAST);

   // The line level chosen here is registered, so tx trails the state by one cycle.
   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      tx_next    = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (baud_done) state_next = DATA;
         end
         DATA: begin
            tx_next = shift_reg[0];
            if (baud_done && bit_idx == 4'(FRAME_BITS - 1)) state_next = STOP;
         end
         STOP: begin
            if (baud_done) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state <= state_next;
         tx    <= tx_next;
         busy  <= (state != IDLE);
         if (state_next != state || baud_done) baud_cnt <= '0;
         else                                  baud_cnt <= baud_cnt + 1'b1;
         if (fifo_pop)                     shift_reg <= fifo_dout;
         else if (state == DATA && baud_done) shift_reg <= shift_reg >> 1;
         if (state != DATA)  bit_idx <= '0;
         else if (baud_done) bit_idx <= bit_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: stimulus queues expected words, a line decoder pops and compares.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 11 * CPB;

   logic clock;
   logic reset;
   logic tx;
   logic busy;

   int   cyc;
   int   checks;
   int   errors;
   int   frames_rx;
   int   last_push_edge;
   logic [8:0] exp_q[$];
   int   starts[$];

   uart_tx_buffered_if bus();

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .tx    (tx),
      .busy  (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drive one push on the next falling edge; it is sampled on the following rising edge.
   task automatic applyStimulus(input logic [8:0] word, input bit accept);
      @(negedge clock);
      bus.send    = 1'b1;
      bus.data_tx = word;
      last_push_edge = cyc + 1;
      #1;
      checkOutput("ready_at_push", int'(bus.ready), int'(accept));
      checkOutput("overflow_at_push", int'(bus.overflow), int'(!accept));
      if (accept) exp_q.push_back(word);
   endtask

   task automatic stopStimulus();
      @(negedge clock);
      bus.send    = 1'b0;
      bus.data_tx = 9'h155;
   endtask

   task automatic waitCycle(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic waitFrames(input int target, input int budget);
      int i;
      i = 0;
      while (frames_rx < target && i < budget) begin
         @(negedge clock);
         i++;
      end
      checkOutput("frames_seen", frames_rx, target);
   endtask

   // Line decoder: samples each bit at its midpoint and scores the word against the queue.
   initial begin
      bit         rx_active;
      int         rx_cnt;
      logic [8:0] rx_word;
      logic [8:0] exp_word;
      rx_active = 1'b0;
      rx_cnt    = 0;
      rx_word   = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            rx_active = 1'b0;
         end else if (!rx_active) begin
            if (tx == 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
               starts.push_back(cyc);
            end
         end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) checkOutput("start_mid", int'(tx), 0);
            if (rx_cnt >= CPB + CPB / 2 && rx_cnt <= 9 * CPB + CPB / 2 && (rx_cnt % CPB) == CPB / 2)
               rx_word[(rx_cnt - CPB - CPB / 2) / CPB] = tx;
            if (rx_cnt == 10 * CPB + CPB / 2) begin
               checkOutput("stop_bit", int'(tx), 1);
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_frame", int'(rx_word), -1);
               end else begin
                  exp_word = exp_q.pop_front();
                  checkOutput("rx_word", int'(rx_word), int'(exp_word));
               end
               frames_rx++;
               rx_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit exp_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
      int n;
      int s0;
      int fr;
      int low_seen;

      cyc         = 0;
      checks      = 0;
      errors      = 0;
      frames_rx   = 0;
      bus.send    = 1'b0;
      bus.data_tx = '0;
      reset       = 1'b1;
      #1 reset    = 1'b0;
      #1;
      checkOutput("reset_tx", int'(tx), 1);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_ready", int'(bus.ready), 1);
      checkOutput("reset_overflow", int'(bus.overflow), 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;

      $display("[TB] idle after reset");
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         checkOutput("idle_lines", int'({tx, bus.ready, busy, bus.overflow}), 4'b1100);
      end

      $display("[TB] single word 0x1A5");
      s0 = starts.size();
      applyStimulus(9'h1A5, 1'b1);
      n = last_push_edge;
      stopStimulus();
      for (int c = n + 2; c <= n + 45; c++) begin
         waitCycle(c);
         checkOutput("tx_wave", int'(tx), int'(exp_bits[(c - n - 2) / CPB]));
      end
      checkOutput("busy_before_fall", int'(busy), 1);
      waitCycle(n + 46);
      checkOutput("busy_fall", int'(busy), 0);
      waitFrames(1, 100);
      checkOutput("first_start", starts[s0], n + 2);

      $display("[TB] three words back-to-back");
      s0 = starts.size();
      applyStimulus(9'h000, 1'b1);
      n = last_push_edge;
      applyStimulus(9'h1FF, 1'b1);
      applyStimulus(9'h0AA, 1'b1);
      stopStimulus();
      waitFrames(4, 4 * FRAME);
      checkOutput("b2b_first_start", starts[s0], n + 2);
      checkOutput("b2b_gap_1", starts[s0 + 1] - starts[s0], FRAME);
      checkOutput("b2b_gap_2", starts[s0 + 2] - starts[s0 + 1], FRAME);
      waitCycle(n + 133);
      checkOutput("b2b_busy_end", int'(busy), 1);
      waitCycle(n + 134);
      checkOutput("b2b_busy_fall", int'(busy), 0);

      $display("[TB] six words into an idle line");
      applyStimulus(9'h101, 1'b1);
      applyStimulus(9'h0FE, 1'b1);
      applyStimulus(9'h033, 1'b1);
      applyStimulus(9'h1CC, 1'b1);
      applyStimulus(9'h055, 1'b1);
      applyStimulus(9'h1E1, 1'b0);
      stopStimulus();
      #1;
      checkOutput("overflow_single_pulse", int'(bus.overflow), 0);
      waitFrames(9, 6 * FRAME);
      repeat (60) @(negedge clock);
      checkOutput("no_sixth_frame", frames_rx, 9);
      checkOutput("six_queue_empty", exp_q.size(), 0);

      $display("[TB] reset during data bit 4");
      applyStimulus(9'h1EF, 1'b1);
      n = last_push_edge;
      stopStimulus();
      waitCycle(n + 23);
      checkOutput("bit4_low", int'(tx), 0);
      checkOutput("bit4_busy", int'(busy), 1);
      #1 reset = 1'b0;
      #1;
      checkOutput("abort_tx", int'(tx), 1);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_ready", int'(bus.ready), 1);
      exp_q.delete();
      repeat (3) @(negedge clock);
      reset    = 1'b1;
      s0       = starts.size();
      fr       = frames_rx;
      low_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (tx == 1'b0) low_seen++;
      end
      checkOutput("post_reset_low_cycles", low_seen, 0);
      checkOutput("post_reset_starts", starts.size(), s0);
      checkOutput("post_reset_frames", frames_rx, fr);

      $display("[TB] push while full at stop-to-start pop");
      fr = frames_rx;
      applyStimulus(9'h011, 1'b1);
      n = last_push_edge;
      applyStimulus(9'h022, 1'b1);
      applyStimulus(9'h044, 1'b1);
      applyStimulus(9'h088, 1'b1);
      applyStimulus(9'h110, 1'b1);
      stopStimulus();
      checkOutput("full_ready", int'(bus.ready), 0);
      waitCycle(n + 43);
      applyStimulus(9'h1F0, 1'b0);
      applyStimulus(9'h00F, 1'b1);
      stopStimulus();
      checkOutput("refill_ready", int'(bus.ready), 0);
      waitFrames(fr + 6, 7 * FRAME);
      repeat (60) @(negedge clock);
      checkOutput("final_queue_empty", exp_q.size(), 0);
      checkOutput("final_frames", frames_rx, fr + 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
